// File: rtl/oddr_waveform_pkg.sv
// Shared types and constants for the ODDR waveform generator: wave modes,
// per-channel configuration record and the PRBS7 seed.
package oddr_waveform_pkg;

    localparam int WAVE_DIV_WIDTH = 16;
    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    typedef enum logic [1:0] {
        WAVE_OFF    = 2'd0,
        WAVE_STATIC = 2'd1,
        WAVE_CLOCK  = 2'd2,
        WAVE_PRBS7  = 2'd3
    } wavemode_t;

    typedef struct packed {
        wavemode_t                 mode;
        logic                      level;
        logic [WAVE_DIV_WIDTH-1:0] half;
        logic [WAVE_DIV_WIDTH-1:0] phase;
    } chan_cfg_t;

    localparam chan_cfg_t CFG_RESET = '{mode: WAVE_OFF, level: 1'b0, half: '0, phase: '0};

    // A half-period of zero would never terminate a level, so it is run as one UI.
    function automatic logic [WAVE_DIV_WIDTH-1:0] half_eff(input logic [WAVE_DIV_WIDTH-1:0] half);
        return (half == '0) ? WAVE_DIV_WIDTH'(1) : half;
    endfunction

endpackage

// File: rtl/oddr_waveform_channel.sv
// One ODDR output channel: active config, clock divider state, PRBS7 LFSR and
// the registered D1/D2 pair (D1 is the earlier UI of each clk).
module oddr_waveform_channel
    import oddr_waveform_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      apply,
    input  chan_cfg_t shadow,
    output logic      active,
    output logic      d1,
    output logic      d2
);

    localparam int W = WAVE_DIV_WIDTH;

    wavemode_t      mode_q;
    logic           level_q;
    logic [W-1:0]   heff_q;
    logic [W-1:0]   cnt_q;
    logic           lvl_q;
    logic [6:0]     lfsr_q;

    logic [W-1:0]   heff_new;
    logic [W-1:0]   cnt_mid, cnt_end;
    logic           lvl_mid, lvl_end;
    logic [6:0]     lfsr_mid, lfsr_end;
    logic           d1_next, d2_next;

    assign heff_new = half_eff(shadow.half);

    // Two UI steps per clk, both derived from the registered state.
    always_comb begin
        cnt_mid = cnt_q + W'(1);
        lvl_mid = lvl_q;
        if (cnt_mid == heff_q) begin
            cnt_mid = '0;
            lvl_mid = ~lvl_q;
        end
        cnt_end = cnt_mid + W'(1);
        lvl_end = lvl_mid;
        if (cnt_end == heff_q) begin
            cnt_end = '0;
            lvl_end = ~lvl_mid;
        end
        lfsr_mid = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        lfsr_end = {lfsr_mid[5:0], lfsr_mid[6] ^ lfsr_mid[5]};
    end

    always_comb begin
        d1_next = 1'b0;
        d2_next = 1'b0;
        case (mode_q)
            WAVE_STATIC: begin
                d1_next = level_q;
                d2_next = level_q;
            end
            WAVE_CLOCK: begin
                d1_next = lvl_q;
                d2_next = lvl_mid;
            end
            WAVE_PRBS7: begin
                d1_next = lfsr_q[6];
                d2_next = lfsr_mid[6];
            end
            default: ;
        endcase
    end

    // Outputs are computed from the pre-apply state, so the old waveform holds through the apply edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= WAVE_OFF;
            level_q <= 1'b0;
            heff_q  <= W'(1);
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            lfsr_q  <= PRBS7_SEED;
            active  <= 1'b0;
            d1      <= 1'b0;
            d2      <= 1'b0;
        end else begin
            active <= (mode_q != WAVE_OFF);
            d1     <= d1_next;
            d2     <= d2_next;
            if (apply) begin
                mode_q  <= shadow.mode;
                level_q <= shadow.level;
                heff_q  <= heff_new;
                cnt_q   <= (shadow.phase < heff_new) ? shadow.phase : '0;
                lvl_q   <= shadow.level;
                lfsr_q  <= PRBS7_SEED;
            end else begin
                if (mode_q == WAVE_CLOCK) begin
                    cnt_q <= cnt_end;
                    lvl_q <= lvl_end;
                end
                if (mode_q == WAVE_PRBS7) begin
                    lfsr_q <= lfsr_end;
                end
            end
        end
    end

endmodule

// File: rtl/oddr_waveform_gen.sv
// Multi-channel ODDR waveform generator: per-channel shadow config written by the
// host, a global apply that restarts every channel on the same edge.
module oddr_waveform_gen
    import oddr_waveform_pkg::*;
#(
    parameter int  NUM_CHANNELS = 4,
    parameter int  DIV_WIDTH    = WAVE_DIV_WIDTH,
    localparam int CHAN_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_wr,
    input  logic [CHAN_W-1:0]       cfg_chan,
    input  logic [1:0]              cfg_mode,
    input  logic                    cfg_level,
    input  logic [DIV_WIDTH-1:0]    cfg_half,
    input  logic [DIV_WIDTH-1:0]    cfg_phase,
    input  logic                    apply,
    output logic [NUM_CHANNELS-1:0] active,
    output logic [NUM_CHANNELS-1:0] ddr_d1,
    output logic [NUM_CHANNELS-1:0] ddr_d2
);

    chan_cfg_t wr_cfg;

    // The stored record is sized by the package; DIV_WIDTH is expected to match it.
    assign wr_cfg = '{mode:  wavemode_t'(cfg_mode),
                      level: cfg_level,
                      half:  WAVE_DIV_WIDTH'(cfg_half),
                      phase: WAVE_DIV_WIDTH'(cfg_phase)};

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        logic      wr_hit;
        chan_cfg_t shadow_q;
        chan_cfg_t shadow_next;

        // Apply sees shadow_next, so a write in the apply cycle is included.
        assign wr_hit      = cfg_wr && (cfg_chan == CHAN_W'(i));
        assign shadow_next = wr_hit ? wr_cfg : shadow_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow_q <= CFG_RESET;
            end else begin
                shadow_q <= shadow_next;
            end
        end

        oddr_waveform_channel u_chan (
            .clk    (clk),
            .rst    (rst),
            .apply  (apply),
            .shadow (shadow_next),
            .active (active[i]),
            .d1     (ddr_d1[i]),
            .d2     (ddr_d2[i])
        );
    end

endmodule
